// File: rtl/smvm_tx.sv
// smvm_tx: streams a sparse-matrix/dense-vector frame onto the SMVM byte port.
// Output is registered (1-cycle lag); vector data is pass-through, nonzero entries prefetched into a FIFO.
module smvm_tx #(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_COLS   = 128
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] cfg_rows,
    input  logic [7:0] cfg_cols,
    output logic       busy,
    input  logic [7:0] vec_data,
    input  logic       vec_valid,
    output logic       vec_ready,
    input  logic [7:0] nz_val,
    input  logic [7:0] nz_col,
    input  logic       nz_ipv,
    input  logic       nz_last,
    input  logic       nz_valid,
    output logic       nz_ready,
    output logic [7:0] data_out,
    output logic       out_valid,
    output logic       done,
    output logic       err_underrun
);

    localparam int              PW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int              CW         = $clog2(FIFO_DEPTH + 1);
    localparam logic [PW-1:0]   PTR_MAX    = PW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0]   CNT_FULL   = CW'(FIFO_DEPTH);
    localparam logic [8:0]      MAX_COLS_W = 9'(MAX_COLS);

    typedef enum logic [2:0] {IDLE, ROWS, COLS, VEC, VAL, IDX, IPV, END} state_t;

    typedef struct packed {
        logic [7:0] val;
        logic [7:0] col;
        logic       ipv;
        logic       last;
    } entry_t;

    state_t        state_q, state_d;
    logic [7:0]    rows_q, rows_d, cols_q, cols_d, vcnt_q, vcnt_d;
    logic [7:0]    data_out_q, data_out_d, cur_col_q, cur_col_d;
    logic          out_valid_q, out_valid_d, done_q, done_d, err_q, err_d;
    logic          cur_ipv_q, cur_ipv_d, cur_last_q, cur_last_d;
    logic          last_seen_q, last_seen_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    entry_t        fifo_mem [FIFO_DEPTH];
    entry_t        head;
    logic          fifo_empty, fifo_full, push, pop, flush, cols_ok;

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == CNT_FULL);
    assign busy       = (state_q != IDLE);
    assign vec_ready  = (state_q == VEC);
    assign nz_ready   = busy && !fifo_full && !last_seen_q;
    assign push       = nz_valid && nz_ready;
    assign head       = fifo_mem[rd_ptr_q];
    assign cols_ok    = (cfg_cols != 8'd0) && ({1'b0, cfg_cols} <= MAX_COLS_W);

    assign data_out     = data_out_q;
    assign out_valid    = out_valid_q;
    assign done         = done_q;
    assign err_underrun = err_q;

    always_comb begin
        state_d     = state_q;
        rows_d      = rows_q;
        cols_d      = cols_q;
        vcnt_d      = vcnt_q;
        data_out_d  = data_out_q;
        out_valid_d = 1'b0;
        done_d      = 1'b0;
        err_d       = err_q;
        cur_col_d   = cur_col_q;
        cur_ipv_d   = cur_ipv_q;
        cur_last_d  = cur_last_q;
        pop         = 1'b0;
        flush       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && cols_ok) begin
                    rows_d  = cfg_rows;
                    cols_d  = cfg_cols;
                    err_d   = 1'b0;
                    flush   = 1'b1;
                    state_d = ROWS;
                end
            end
            ROWS: begin
                data_out_d  = rows_q;
                out_valid_d = 1'b1;
                state_d     = COLS;
            end
            COLS: begin
                data_out_d  = cols_q;
                out_valid_d = 1'b1;
                vcnt_d      = 8'd0;
                state_d     = VEC;
            end
            VEC: begin
                if (vec_valid) begin
                    data_out_d  = vec_data;
                    out_valid_d = 1'b1;
                    if (vcnt_q == cols_q - 8'd1) state_d = VAL;
                    else                         vcnt_d  = vcnt_q + 8'd1;
                end else begin
                    err_d   = 1'b1;
                    flush   = 1'b1;
                    state_d = IDLE;
                end
            end
            VAL: begin
                if (fifo_empty) begin
                    err_d   = 1'b1;
                    flush   = 1'b1;
                    state_d = IDLE;
                end else begin
                    pop         = 1'b1;
                    data_out_d  = head.val;
                    out_valid_d = 1'b1;
                    cur_col_d   = head.col;
                    cur_ipv_d   = head.ipv;
                    cur_last_d  = head.last;
                    state_d     = IDX;
                end
            end
            IDX: begin
                data_out_d  = cur_col_q;
                out_valid_d = 1'b1;
                state_d     = IPV;
            end
            IPV: begin
                data_out_d  = {7'b0, cur_ipv_q};
                out_valid_d = 1'b1;
                state_d     = cur_last_q ? END : VAL;
            end
            END: begin
                // out_valid drops next cycle: that gap is the frame terminator
                done_d  = 1'b1;
                flush   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        last_seen_d = last_seen_q;
        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            cnt_d       = '0;
            last_seen_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + 1'b1;
                if (nz_last) last_seen_d = 1'b1;
            end
            if (pop) rd_ptr_d = (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= '{val: nz_val, col: nz_col, ipv: nz_ipv, last: nz_last};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rows_q      <= 8'd0;
            cols_q      <= 8'd0;
            vcnt_q      <= 8'd0;
            data_out_q  <= 8'd0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cur_col_q   <= 8'd0;
            cur_ipv_q   <= 1'b0;
            cur_last_q  <= 1'b0;
            last_seen_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            rows_q      <= rows_d;
            cols_q      <= cols_d;
            vcnt_q      <= vcnt_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cur_col_q   <= cur_col_d;
            cur_ipv_q   <= cur_ipv_d;
            cur_last_q  <= cur_last_d;
            last_seen_q <= last_seen_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_smvm_tx.sv
// tb_smvm_tx: drives frames cycle by cycle and compares the byte stream with a frame-level model.
module tb_smvm_tx;
    logic       clk = 1'b0;
    logic       rst_n, start, busy, vec_valid, vec_ready;
    logic [7:0] cfg_rows, cfg_cols, vec_data, nz_val, nz_col, data_out;
    logic       nz_ipv, nz_last, nz_valid, nz_ready, out_valid, done, err_underrun;

    smvm_tx dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_rows(cfg_rows), .cfg_cols(cfg_cols),
        .busy(busy), .vec_data(vec_data), .vec_valid(vec_valid), .vec_ready(vec_ready),
        .nz_val(nz_val), .nz_col(nz_col), .nz_ipv(nz_ipv), .nz_last(nz_last),
        .nz_valid(nz_valid), .nz_ready(nz_ready), .data_out(data_out), .out_valid(out_valid),
        .done(done), .err_underrun(err_underrun)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] vec_q[$];
    logic [7:0] ev[$];
    logic [7:0] ec[$];
    logic       eipv[$];
    logic [7:0] obs[$];
    int         push_cyc[$];
    int         done_cnt, first_v, busy_rise, gaps, rdy8, acc8;
    bit         timeout, got_rst;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_vec++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic check_idle_zero(input string t);
        chk({t, "_dout"}, 32'(data_out), 32'd0);
        chk({t, "_ovld"}, 32'(out_valid), 32'd0);
        chk({t, "_busy"}, 32'(busy), 32'd0);
        chk({t, "_done"}, 32'(done), 32'd0);
        chk({t, "_err"}, 32'(err_underrun), 32'd0);
        chk({t, "_vrdy"}, 32'(vec_ready), 32'd0);
        chk({t, "_nrdy"}, 32'(nz_ready), 32'd0);
    endtask

    task automatic gen(input int cols, input int n);
        vec_q.delete(); ev.delete(); ec.delete(); eipv.delete();
        for (int i = 0; i < cols; i++) vec_q.push_back(8'($urandom));
        for (int i = 0; i < n; i++) begin
            ev.push_back(8'($urandom));
            ec.push_back(8'($urandom_range(0, cols - 1)));
            eipv.push_back(1'($urandom));
        end
    endtask

    // Sample at negedge, then drive this cycle's inputs; a handshake seen here lands on the next posedge.
    task automatic run_frame(input logic [7:0] rows, input logic [7:0] cols, input int drop_k,
                             input int period, input int rst_at);
        int vi, ni, next_offer;
        bit pend, ended;
        obs.delete(); push_cyc.delete();
        done_cnt = 0; first_v = -1; busy_rise = -1; gaps = 0; rdy8 = -1; acc8 = -1;
        got_rst = 1'b0; ended = 1'b0;
        vi = 0; ni = 0; next_offer = 0; pend = 1'b0;
        @(negedge clk);
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (busy && busy_rise < 0) busy_rise = cyc;
            if (out_valid) begin
                if (first_v < 0) first_v = cyc;
                obs.push_back(data_out);
            end else if (busy && first_v >= 0) gaps++;
            if (done) done_cnt++;
            if (cyc == 8) begin rdy8 = int'(nz_ready); acc8 = ni; end
            if (rst_at > 0 && obs.size() == rst_at) begin
                rst_n = 1'b0; got_rst = 1'b1; ended = 1'b1;
                break;
            end
            if (busy_rise >= 0 && !busy) begin ended = 1'b1; break; end
            start     = (cyc < 3);
            cfg_rows  = (cyc == 0) ? rows : 8'($urandom);
            cfg_cols  = (cyc == 0) ? cols : 8'($urandom_range(1, 8));
            vec_valid = (vi < int'(cols)) && (vi != drop_k);
            vec_data  = (vi < int'(cols)) ? vec_q[vi] : 8'($urandom);
            if (vec_valid && vec_ready) vi++;
            if (!pend && ni < ev.size() && cyc >= next_offer) pend = 1'b1;
            nz_valid = pend;
            if (pend) begin
                nz_val  = ev[ni];
                nz_col  = ec[ni];
                nz_ipv  = eipv[ni];
                nz_last = (ni == ev.size() - 1);
            end
            if (pend && nz_ready) begin
                push_cyc.push_back(cyc);
                ni++; pend = 1'b0; next_offer = cyc + period;
            end
            @(negedge clk);
        end
        timeout = !ended;
        start = 1'b0; vec_valid = 1'b0; nz_valid = 1'b0; nz_last = 1'b0;
    endtask

    // Frame model: byte k of the frame is due at cycle 2+k; entry i must be pushed before its VAL cycle.
    task automatic check_frame(input string tag, input logic [7:0] rows, input logic [7:0] cols,
                               input int drop_k);
        logic [7:0] exp_q[$];
        int len;
        bit aborted;
        exp_q.push_back(rows);
        exp_q.push_back(cols);
        for (int i = 0; i < int'(cols); i++) exp_q.push_back(vec_q[i]);
        for (int i = 0; i < ev.size(); i++) begin
            exp_q.push_back(ev[i]);
            exp_q.push_back(ec[i]);
            exp_q.push_back({7'b0, eipv[i]});
        end
        aborted = 1'b0;
        len = exp_q.size();
        if (drop_k >= 0 && drop_k < int'(cols)) begin
            aborted = 1'b1; len = 2 + drop_k;
        end else begin
            for (int i = 0; i < ev.size(); i++) begin
                if (i >= push_cyc.size() || push_cyc[i] >= 3 + int'(cols) + 3 * i) begin
                    aborted = 1'b1; len = 2 + int'(cols) + 3 * i;
                    break;
                end
            end
        end
        chk({tag, "_timeout"}, 32'(timeout), 32'd0);
        chk({tag, "_len"}, obs.size(), len);
        for (int i = 0; i < len && i < obs.size(); i++)
            chk($sformatf("%s_b%0d", tag, i), 32'(obs[i]), 32'(exp_q[i]));
        chk({tag, "_done"}, done_cnt, aborted ? 0 : 1);
        chk({tag, "_err"}, 32'(err_underrun), 32'(aborted));
        chk({tag, "_busyrise"}, busy_rise, 1);
        chk({tag, "_first"}, first_v, 2);
        chk({tag, "_gaps"}, gaps, 0);
    endtask

    initial begin
        logic [7:0] r;
        int c, n, p, d;
        rst_n = 1'b0; start = 1'b0; cfg_rows = 8'd0; cfg_cols = 8'd0;
        vec_data = 8'd0; vec_valid = 1'b0; nz_val = 8'd0; nz_col = 8'd0;
        nz_ipv = 1'b0; nz_last = 1'b0; nz_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_zero("rst");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_zero("post_rst");

        start = 1'b1; cfg_rows = 8'd5; cfg_cols = 8'd0;
        @(negedge clk);
        chk("start_cols0", 32'(busy), 32'd0);
        cfg_cols = 8'd129;
        @(negedge clk);
        chk("start_cols129", 32'(busy), 32'd0);
        start = 1'b0;

        vec_q = '{8'd5, 8'hFF, 8'd7};
        ev    = '{8'd3, 8'hFC, 8'd9};
        ec    = '{8'd0, 8'd2, 8'd1};
        eipv  = '{1'b1, 1'b0, 1'b1};
        run_frame(8'd2, 8'd3, -1, 1, 0);
        check_frame("basic", 8'd2, 8'd3, -1);

        vec_q = '{8'h42};
        ev = '{8'd1}; ec = '{8'd0}; eipv = '{1'b1};
        run_frame(8'd1, 8'd1, -1, 1, 0);
        check_frame("one_entry", 8'd1, 8'd1, -1);
        chk("one_entry_busy_after", 32'(busy), 32'd0);

        gen(4, 2);
        run_frame(8'd3, 8'd4, 1, 1, 0);
        check_frame("vec_starve", 8'd3, 8'd4, 1);

        gen(3, 2);
        run_frame(8'd7, 8'd3, -1, 1, 0);
        check_frame("after_vec_abort", 8'd7, 8'd3, -1);

        gen(1, 4);
        run_frame(8'd4, 8'd1, -1, 5, 0);
        check_frame("nz_starve", 8'd4, 8'd1, -1);

        gen(2, 2);
        run_frame(8'd9, 8'd2, -1, 1, 0);
        check_frame("err_cleared", 8'd9, 8'd2, -1);

        gen(8, 6);
        run_frame(8'd6, 8'd8, -1, 1, 0);
        check_frame("fifo_full", 8'd6, 8'd8, -1);
        chk("fifo_full_rdy", rdy8, 0);
        chk("fifo_full_held", acc8, 4);

        gen(3, 3);
        run_frame(8'd2, 8'd3, -1, 1, 9);
        chk("mid_rst_hit", 32'(got_rst), 32'd1);
        #1;
        check_idle_zero("mid_rst");
        chk("mid_rst_nodone", done_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        gen(2, 3);
        run_frame(8'd5, 8'd2, -1, 1, 0);
        check_frame("post_mid_rst", 8'd5, 8'd2, -1);

        for (int f = 0; f < 6; f++) begin
            c = int'($urandom_range(1, 10));
            n = int'($urandom_range(1, 5));
            p = int'($urandom_range(1, 4));
            d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, c - 1)) : -1;
            r = 8'($urandom);
            gen(c, n);
            run_frame(r, 8'(c), d, p, 0);
            check_frame($sformatf("rnd%0d", f), r, 8'(c), d);
        end

        gen(128, 2);
        run_frame(8'd1, 8'd128, -1, 1, 0);
        check_frame("max_cols", 8'd1, 8'd128, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/smvm_tx.md
SMVM_TX -- requirements
Module: smvm_tx

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, depth of the internal nonzero-entry FIFO.
REQ-002 Parameter MAX_COLS, default 128, largest legal column count (vector length).
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  frame request; sampled only in IDLE.
REQ-006 cfg_rows  input  8  row count, captured on accepted start.
REQ-007 cfg_cols  input  8  column count, captured on accepted start; legal range 1..MAX_COLS.
REQ-008 busy  output  1  high from the cycle after start acceptance until the return to IDLE.
REQ-009 vec_data  input  8  dense vector element, signed two's complement.
REQ-010 vec_valid  input  1  vec_data valid.
REQ-011 vec_ready  output  1  block takes vec_data this cycle.
REQ-012 nz_val  input  8  nonzero matrix value, signed.
REQ-013 nz_col  input  8  column index of nz_val.
REQ-014 nz_ipv  input  1  row-start flag (IPV bit) of the entry.
REQ-015 nz_last  input  1  marks the final nonzero entry of the frame.
REQ-016 nz_valid / nz_ready  input / output  1 / 1  nonzero-entry handshake; transfer when both high.
REQ-017 data_out  output  8  serial byte to the SMVM data_in port; registered.
REQ-018 out_valid  output  1  data_out valid, drives SMVM in_valid; registered.
REQ-019 done  output  1  one-cycle pulse on normal frame completion.
REQ-020 err_underrun  output  1  sticky frame-abort flag; cleared on next accepted start.

Function
REQ-021 FSM states SHALL be IDLE, ROWS, COLS, VEC, VAL, IDX, IPV, END.
REQ-022 IDLE: start=1 with cfg_cols in 1..MAX_COLS -> capture config, clear err_underrun, go ROWS; start with cfg_cols=0 or >MAX_COLS SHALL be ignored.
REQ-023 Frame byte order on data_out, one byte per cycle, out_valid continuously high: rows, cols, cols vector bytes, then per entry {val, col, {7'b0, ipv}}.
REQ-024 ROWS emits rows next cycle; COLS emits cols next cycle; frame's first byte appears 1 cycle after start acceptance.
REQ-025 VEC: vec_ready=1 for exactly cols cycles; byte accepted in cycle t SHALL appear on data_out in cycle t+1.
REQ-026 Vector starvation: vec_ready=1 and vec_valid=0 -> abort: out_valid=0 next cycle, err_underrun=1, go IDLE, no done.
REQ-027 nz_ready = busy and FIFO not full and nz_last not yet accepted this frame; entries SHALL be accepted during ROWS, COLS, VEC and entry phases (prefetch).
REQ-028 VAL pops the FIFO head and emits val; IDX emits col; IPV emits ipv byte; IPV -> VAL unless the popped entry had last=1, then -> END.
REQ-029 Entry starvation: on entering VAL with FIFO empty -> same abort as REQ-026.
REQ-030 END: out_valid=0 (terminator seen by SMVM in VAL_IN), done=1 this cycle, then IDLE; total frame = 2+cols+3*N valid cycles plus 1 terminator cycle.
REQ-031 Simultaneous push and pop on a full FIFO SHALL be allowed only if nz_ready was high (no push on full); push+pop on non-empty FIFO keeps count.
REQ-032 At least one entry per frame; nz_last on first entry gives N=1.
REQ-033 start while busy SHALL be ignored; vec_valid/nz_valid outside their windows SHALL not be consumed.
REQ-034 FIFO SHALL be flushed and last-seen flag cleared on abort, END and start acceptance.

Reset
REQ-035 rst_n low SHALL force IDLE, out_valid=0, data_out=0, busy=0, done=0, err_underrun=0, vec_ready=0, nz_ready=0, FIFO empty, config registers 0.
REQ-036 Reset mid-frame SHALL abort immediately with no done and no error flag; next frame starts clean.

Verification
REQ-037 rows=2, cols=3, vec {5,-1,7}, entries {(3,0,1),(-4,2,0),(9,1,1,last)} -> bytes 02,03,05,FF,07,03,00,01,FC,02,00,09,01,01 contiguous, then out_valid=0, done pulse.
REQ-038 cols=1, one entry (1,0,1,last) preloaded -> 6 valid bytes, terminator, done; busy low after END.
REQ-039 vec_valid dropped at 2nd vector byte (cols=4) -> out_valid low next cycle, err_underrun=1, no done, FIFO empty.
REQ-040 Entries fed 1 per 5 cycles, cols=1 -> VAL finds FIFO empty -> abort, err_underrun=1; next start clears flag.
REQ-041 6 entries pushed back-to-back, FIFO_DEPTH=4 -> nz_ready low when 4 held, no entry lost, output matches order.
REQ-042 rst_n asserted during IDX of entry 2 -> outputs zero asynchronously; new frame cols=2 completes correctly.
